// File: rtl/mrd_mem_pkt.sv
// mrd_mem_pkt: shared constants and framer state encoding for the DFT memory sink path
package mrd_mem_pkt;

    localparam int MRD_MIN_PTS = 12;
    localparam int MRD_MAX_PTS = 1200;
    localparam int wDATA_IN    = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_MEM,
        ST_STREAM,
        ST_PAD,
        ST_FLUSH,
        ST_GAP
    } frm_state_e;

endpackage

// File: rtl/mrd_len_check.sv
// mrd_len_check: combinational legality check of a DFT length (range and multiple of 12)
module mrd_len_check
    import mrd_mem_pkt::*;
#(
    parameter int MIN_PTS = MRD_MIN_PTS,
    parameter int MAX_PTS = MRD_MAX_PTS
) (
    input  logic [11:0] pts,
    output logic        legal
);

    localparam logic [11:0] MIN_L = 12'(MIN_PTS);
    localparam logic [11:0] MAX_L = 12'(MAX_PTS);

    assign legal = (pts >= MIN_L) && (pts <= MAX_L) && ((pts % 12'd12) == 12'd0);

endmodule

// File: rtl/mrd_sink_framer.sv
// mrd_sink_framer: frames raw samples into exactly dftpts-long packets for the DFT memory sink
module mrd_sink_framer
    import mrd_mem_pkt::*;
#(
    parameter int MAX_PTS = MRD_MAX_PTS,
    parameter int MIN_PTS = MRD_MIN_PTS,
    parameter int MIN_GAP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    input  logic [11:0]         cfg_dftpts,
    output logic                cfg_ready,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [wDATA_IN-1:0] s_real,
    input  logic [wDATA_IN-1:0] s_imag,
    input  logic                s_last,
    input  logic                mem_rdy,
    output logic                sop,
    output logic                eop,
    output logic                valid,
    output logic [wDATA_IN-1:0] din_real,
    output logic [wDATA_IN-1:0] din_imag,
    output logic [11:0]         dftpts,
    output logic                cfg_err,
    output logic                short_err,
    output logic                long_err
);

    localparam logic [2:0] GAP_LAST = 3'(MIN_GAP - 1);

    frm_state_e          state_q, state_d;
    logic [11:0]         len_q, len_d;
    logic [10:0]         cnt_q, cnt_d;
    logic [2:0]          gap_q, gap_d;
    logic                sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
    logic [wDATA_IN-1:0] re_q, re_d, im_q, im_d;
    logic [11:0]         dftpts_q, dftpts_d;
    logic                cfg_err_q, cfg_err_d, short_err_q, short_err_d, long_err_q, long_err_d;
    logic                cfg_legal;
    logic                cnt_last;

    mrd_len_check #(.MIN_PTS(MIN_PTS), .MAX_PTS(MAX_PTS)) u_len_check (
        .pts   (cfg_dftpts),
        .legal (cfg_legal)
    );

    assign cnt_last  = ({1'b0, cnt_q} == (len_q - 12'd1));
    assign cfg_ready = rst_n && (state_q == ST_IDLE);
    assign s_ready   = rst_n && ((state_q == ST_STREAM) || (state_q == ST_FLUSH));

    assign sop       = sop_q;
    assign eop       = eop_q;
    assign valid     = valid_q;
    assign din_real  = re_q;
    assign din_imag  = im_q;
    assign dftpts    = dftpts_q;
    assign cfg_err   = cfg_err_q;
    assign short_err = short_err_q;
    assign long_err  = long_err_q;

    // next-state and next output beat; outputs default to an idle beat each cycle
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        gap_d       = 3'd0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        valid_d     = 1'b0;
        re_d        = '0;
        im_d        = '0;
        dftpts_d    = dftpts_q;
        cfg_err_d   = 1'b0;
        short_err_d = 1'b0;
        long_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_legal) begin
                        len_d   = cfg_dftpts;
                        state_d = ST_WAIT_MEM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rdy) begin
                    cnt_d   = 11'd0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (s_valid) begin
                    valid_d  = 1'b1;
                    sop_d    = (cnt_q == 11'd0);
                    eop_d    = cnt_last;
                    re_d     = s_real;
                    im_d     = s_imag;
                    dftpts_d = (cnt_q == 11'd0) ? len_q : dftpts_q;
                    cnt_d    = cnt_q + 11'd1;
                    if (cnt_last) begin
                        state_d = s_last ? ST_GAP : ST_FLUSH;
                    end else if (s_last) begin
                        short_err_d = 1'b1;
                        state_d     = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                valid_d = 1'b1;
                eop_d   = cnt_last;
                cnt_d   = cnt_q + 11'd1;
                state_d = cnt_last ? ST_GAP : ST_PAD;
            end
            ST_FLUSH: begin
                if (s_valid && s_last) begin
                    long_err_d = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d   = gap_q + 3'd1;
                state_d = (gap_q == GAP_LAST) ? ST_IDLE : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and registered output beat; reset aborts any packet in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            valid_q     <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
            dftpts_q    <= '0;
            cfg_err_q   <= 1'b0;
            short_err_q <= 1'b0;
            long_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            valid_q     <= valid_d;
            re_q        <= re_d;
            im_q        <= im_d;
            dftpts_q    <= dftpts_d;
            cfg_err_q   <= cfg_err_d;
            short_err_q <= short_err_d;
            long_err_q  <= long_err_d;
        end
    end

endmodule

// File: tb/tb_mrd_sink_framer.sv
// tb_mrd_sink_framer: directed scoreboard bench for the sink framer
module tb_mrd_sink_framer;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [17:0] re;
        logic [17:0] im;
        logic [11:0] pts;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [11:0] cfg_dftpts = '0;
    logic        s_valid = 1'b0;
    logic [17:0] s_real = '0;
    logic [17:0] s_imag = '0;
    logic        s_last = 1'b0;
    logic        mem_rdy = 1'b0;
    logic        cfg_ready, s_ready, sop, eop, valid;
    logic [17:0] din_real, din_imag;
    logic [11:0] dftpts;
    logic        cfg_err, short_err, long_err;

    int checks = 0;
    int errors = 0;
    int n_cfg = 0;
    int n_short = 0;
    int n_long = 0;
    int idx = 0;
    int len = 0;
    beat_t exp_q[$];

    mrd_sink_framer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_dftpts (cfg_dftpts),
        .cfg_ready  (cfg_ready),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .s_last     (s_last),
        .mem_rdy    (mem_rdy),
        .sop        (sop),
        .eop        (eop),
        .valid      (valid),
        .din_real   (din_real),
        .din_imag   (din_imag),
        .dftpts     (dftpts),
        .cfg_err    (cfg_err),
        .short_err  (short_err),
        .long_err   (long_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] re, input logic [17:0] im);
        beat_t b;
        if (idx < len) begin
            b.sop = (idx == 0);
            b.eop = (idx == len - 1);
            b.re  = re;
            b.im  = im;
            b.pts = 12'(len);
            exp_q.push_back(b);
        end
        idx++;
    endtask

    task automatic send_cfg(input int l, input bit legal);
        int n = 0;
        cfg_valid  = 1'b1;
        cfg_dftpts = 12'(l);
        while (!cfg_ready && n < 200) begin
            tick();
            n++;
        end
        check("cfg_ready_wait", cfg_ready, 1);
        if (legal) begin
            len = l;
            idx = 0;
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [17:0] re, input logic [17:0] im, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_imag  = im;
        s_last  = last;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        check("s_ready_wait", s_ready, 1);
        push(re, im);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pad_expect(input int n);
        for (int i = 0; i < n; i++) push(18'd0, 18'd0);
    endtask

    // scoreboard: every valid beat must match the oldest expected beat
    always @(negedge clk) begin
        beat_t e;
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {sop, eop, din_real, din_imag, dftpts}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", {sop, eop, din_real, din_imag, dftpts}, e);
            end
        end
        if (cfg_err) n_cfg++;
        if (short_err) n_short++;
        if (long_err) n_long++;
    end

    initial begin
        logic [17:0] r, m;
        // reset state
        tick();
        tick();
        check("reset_outs", {cfg_ready, s_ready, sop, eop, valid, din_real, din_imag, dftpts,
                             cfg_err, short_err, long_err}, 64'd0);
        rst_n   = 1'b1;
        mem_rdy = 1'b1;
        tick();
        check("idle_cfg_ready", cfg_ready, 1);
        // 12-point clean packet, latency and gap timing
        send_cfg(12, 1);
        for (int i = 0; i < 12; i++) begin
            send(18'(i * 7 + 1), 18'(-i - 3), i == 11);
            if (i == 0) check("latency_sop", {valid, sop}, 2'b11);
        end
        check("t1_eop", {valid, eop, dftpts}, {1'b1, 1'b1, 12'd12});
        check("t1_errs", {cfg_err, short_err, long_err}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_cfg_ready", cfg_ready, 0);
        end
        tick();
        check("gap_release", cfg_ready, 1);
        // 24-point packet with upstream stalls
        send_cfg(24, 1);
        for (int i = 0; i < 24; i++) begin
            r = 18'($urandom);
            m = 18'($urandom);
            send(r, m, i == 23);
            if (i < 23) begin
                tick();
                check("t2_stall", {valid, sop, eop, din_real, din_imag, dftpts},
                      {1'b0, 1'b0, 1'b0, 18'd0, 18'd0, 12'd24});
            end
        end
        // 36-point short packet, s_last on sample 30
        send_cfg(36, 1);
        for (int i = 0; i < 30; i++) send(18'(i + 100), 18'(i + 200), i == 29);
        check("t3_short_err", short_err, 1);
        pad_expect(6);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t3_pad", {valid, din_real, din_imag}, {1'b1, 18'd0, 18'd0});
        end
        tick();
        check("t3_after_pad", valid, 0);
        // single sample that is also s_last
        send_cfg(12, 1);
        send(18'h2aaaa, 18'h15555, 1'b1);
        check("single_sop_short", {sop, short_err}, 2'b11);
        pad_expect(11);
        for (int i = 0; i < 11; i++) tick();
        // 12-point long packet, 15 samples
        send_cfg(12, 1);
        for (int i = 0; i < 15; i++) begin
            send(18'(i + 50), 18'(i + 60), i == 14);
            if (i == 11) check("t5_eop12", {valid, eop}, 2'b11);
            if (i == 12) check("t5_no_beat13", valid, 0);
        end
        check("t5_long_err", long_err, 1);
        // illegal lengths
        send_cfg(13, 0);
        check("cfg_err_13", {cfg_err, cfg_ready}, 2'b11);
        send_cfg(0, 0);
        check("cfg_err_0", {cfg_err, cfg_ready}, 2'b11);
        send_cfg(1212, 0);
        check("cfg_err_1212", {cfg_err, cfg_ready}, 2'b11);
        tick();
        check("cfg_err_no_sop", {sop, valid, cfg_err}, 3'b000);
        // 60-point packet held off by mem_rdy, then reset mid-stream
        mem_rdy = 1'b0;
        send_cfg(60, 1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("wait_mem", {s_ready, valid, sop, cfg_ready}, 4'b0000);
        end
        mem_rdy = 1'b1;
        for (int i = 0; i < 30; i++) send(18'(i + 300), 18'(i + 400), 1'b0);
        check("t6_mid_stream", {valid, eop, dftpts}, {1'b1, 1'b0, 12'd60});
        rst_n = 1'b0;
        tick();
        check("rst_mid_outs", {cfg_ready, s_ready, sop, eop, valid, din_real, din_imag, dftpts,
                               cfg_err, short_err, long_err}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {cfg_ready, valid}, 2'b10);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("err_counts", {8'(n_cfg), 8'(n_short), 8'(n_long)}, {8'd3, 8'd2, 8'd1});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
